// File: rtl/lpddr3_lane_dly_move_ctrl.sv
// Wraps each tap-move/tap-load request in an HS_IO_CLK_PAUSE window and keeps RX/TX DQS shadow tap counters.
// Latency: accept at T, DONE at T+LEAD+N*(GAP+1)+TRAIL+1 (load: T+LEAD+GAP+TRAIL+2; zero move: T+1).
// Backpressure: REQ_READY is high only in IDLE; one request in flight, the next is accepted the cycle after DONE.
module lpddr3_lane_dly_move_ctrl #(
   parameter int TAP_MAX     = 255,
   parameter int DEFAULT_TAP = 1,
   parameter int PAUSE_LEAD  = 2,
   parameter int MOVE_GAP    = 3,
   parameter int PAUSE_TRAIL = 2
) (
   input  logic       FAB_CLK,
   input  logic       RESET_N,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_SEL,
   input  logic       REQ_LOAD,
   input  logic       REQ_DIR,
   input  logic [7:0] REQ_COUNT,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] RX_TAP,
   output logic [7:0] TX_TAP,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_MOVE,
   output logic       HS_IO_CLK_PAUSE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic       TX_DELAY_LINE_OUT_OF_RANGE
);

   typedef enum logic [2:0] {IDLE, PRE, PULSE, GAP, POST, FIN} state_t;

   localparam logic [7:0] LEAD_M1  = 8'(PAUSE_LEAD - 1);
   localparam logic [7:0] GAP_M1   = 8'(MOVE_GAP - 1);
   localparam logic [7:0] TRAIL_M1 = 8'(PAUSE_TRAIL - 1);
   localparam logic [7:0] TAP_HI   = 8'(TAP_MAX);
   localparam logic [7:0] TAP_DEF  = 8'(DEFAULT_TAP);

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, tx_q, tx_d;
   logic       ld_req_q, ld_req_d;
   logic       sel_q, sel_d, dir_q, dir_d;
   logic       err_q, err_d;
   logic       move_q, move_d, load_q, load_d;
   logic       pause_q, pause_d, done_q, done_d, rdy_q, rdy_d;

   logic [7:0] cur_tap;
   logic       at_limit;
   logic       oor_sel;

   assign cur_tap  = sel_q ? tx_q : rx_q;
   assign at_limit = dir_q ? (cur_tap == TAP_HI) : (cur_tap == 8'd0);
   assign oor_sel  = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

   // Sequencing, pulse decision on entry to PULSE, and next values of every registered output.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      ld_req_d = ld_req_q;
      sel_d    = sel_q;
      dir_d    = dir_q;
      err_d    = err_q;
      move_d   = 1'b0;
      load_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               sel_d    = REQ_SEL;
               dir_d    = REQ_DIR;
               ld_req_d = REQ_LOAD;
               cnt_d    = REQ_COUNT;
               err_d    = 1'b0;
               if (!REQ_LOAD && REQ_COUNT == 8'd0) begin
                  state_d = FIN;
               end else begin
                  state_d = PRE;
                  timer_d = LEAD_M1;
               end
            end
         end
         PRE: begin
            if (timer_q == 8'd0) state_d = PULSE;
            else                 timer_d = timer_q - 8'd1;
         end
         PULSE: begin
            // A pulse was issued only if the limit pre-check passed; otherwise abort straight to POST.
            if (move_q || load_q) begin
               state_d = GAP;
               timer_d = GAP_M1;
            end else begin
               state_d = POST;
               timer_d = TRAIL_M1;
            end
         end
         GAP: begin
            if (timer_q != 8'd0) begin
               timer_d = timer_q - 8'd1;
            end else if (oor_sel) begin
               err_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = POST;
               timer_d = TRAIL_M1;
            end else if (cnt_q != 8'd0) begin
               state_d = PULSE;
            end else begin
               state_d = POST;
               timer_d = TRAIL_M1;
            end
         end
         POST: begin
            if (timer_q == 8'd0) state_d = FIN;
            else                 timer_d = timer_q - 8'd1;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Entering PULSE: issue the load or a single-tap move, or flag a saturated line.
      if (state_d == PULSE) begin
         if (ld_req_q) begin
            load_d = 1'b1;
            cnt_d  = 8'd0;
            if (sel_q) tx_d = TAP_DEF;
            else       rx_d = TAP_DEF;
         end else if (at_limit) begin
            err_d = 1'b1;
            cnt_d = 8'd0;
         end else begin
            move_d = 1'b1;
            cnt_d  = cnt_q - 8'd1;
            if (sel_q) tx_d = dir_q ? tx_q + 8'd1 : tx_q - 8'd1;
            else       rx_d = dir_q ? rx_q + 8'd1 : rx_q - 8'd1;
         end
      end

      pause_d = (state_d == PRE) || (state_d == PULSE) || (state_d == GAP) || (state_d == POST);
      done_d  = (state_d == FIN);
      rdy_d   = (state_d == IDLE);
   end

   // State and output registers; reset cuts any window or pulse in progress.
   always_ff @(posedge FAB_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         timer_q  <= 8'd0;
         cnt_q    <= 8'd0;
         rx_q     <= TAP_DEF;
         tx_q     <= TAP_DEF;
         ld_req_q <= 1'b0;
         sel_q    <= 1'b0;
         dir_q    <= 1'b0;
         err_q    <= 1'b0;
         move_q   <= 1'b0;
         load_q   <= 1'b0;
         pause_q  <= 1'b0;
         done_q   <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         ld_req_q <= ld_req_d;
         sel_q    <= sel_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         move_q   <= move_d;
         load_q   <= load_d;
         pause_q  <= pause_d;
         done_q   <= done_d;
         rdy_q    <= rdy_d;
      end
   end

   assign REQ_READY            = rdy_q;
   assign DONE                 = done_q;
   assign ERR                  = err_q;
   assign RX_TAP               = rx_q;
   assign TX_TAP               = tx_q;
   assign DELAY_LINE_SEL       = sel_q;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_lpddr3_lane_dly_move_ctrl.sv
// Bench for lpddr3_lane_dly_move_ctrl: directed scenarios plus randomized requests against a timeline model.
// Latency: each request is checked cycle by cycle from accept until REQ_READY returns.
// Backpressure: junk REQ_VALID is driven while busy and must be ignored.
module tb_lpddr3_lane_dly_move_ctrl;

   localparam int L = 2, G = 3, P = 2, TMAX = 255, TDEF = 1, NCYC = 1200;

   logic       FAB_CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       REQ_VALID = 1'b0, REQ_SEL = 1'b0, REQ_LOAD = 1'b0, REQ_DIR = 1'b0;
   logic [7:0] REQ_COUNT = 8'd0;
   logic       RX_OOR = 1'b0, TX_OOR = 1'b0;
   logic       REQ_READY, DONE, ERR, DL_SEL, DL_DIR, DL_LOAD, DL_MOVE, PAUSE;
   logic [7:0] RX_TAP, TX_TAP;

   lpddr3_lane_dly_move_ctrl #(
      .TAP_MAX(TMAX), .DEFAULT_TAP(TDEF), .PAUSE_LEAD(L), .MOVE_GAP(G), .PAUSE_TRAIL(P)
   ) dut (
      .FAB_CLK(FAB_CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL), .REQ_LOAD(REQ_LOAD),
      .REQ_DIR(REQ_DIR), .REQ_COUNT(REQ_COUNT), .DONE(DONE), .ERR(ERR),
      .RX_TAP(RX_TAP), .TX_TAP(TX_TAP), .DELAY_LINE_SEL(DL_SEL), .DELAY_LINE_DIRECTION(DL_DIR),
      .DELAY_LINE_LOAD(DL_LOAD), .DELAY_LINE_MOVE(DL_MOVE), .HS_IO_CLK_PAUSE(PAUSE),
      .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR), .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int n_cmp = 0, n_bad = 0;
   int m_rx = TDEF, m_tx = TDEF;

   // Expected timeline, indexed by cycles after the accept cycle.
   bit e_move [NCYC];
   bit e_load [NCYC];
   bit e_upd  [NCYC];
   int e_tap  [NCYC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walk the request as the lane sees it: lead, then pulse/gap pairs, then trail and DONE.
   task automatic build(input bit sel, input bit ld, input bit dir, input int cnt, input int oor_rel,
                        output int dk, output bit err);
      int t, tap, rem, endk;
      for (int i = 0; i < NCYC; i++) begin
         e_move[i] = 0; e_load[i] = 0; e_upd[i] = 0; e_tap[i] = 0;
      end
      err = 0;
      tap = sel ? m_tx : m_rx;
      if (!ld && cnt == 0) begin
         dk = 1;
      end else begin
         t    = L + 1;
         rem  = ld ? 1 : cnt;
         endk = t;
         while (rem > 0) begin
            if (!ld && ((dir && tap == TMAX) || (!dir && tap == 0))) begin
               err  = 1;
               endk = t;
               break;
            end
            if (ld) begin
               e_load[t] = 1;
               tap = TDEF;
            end else begin
               e_move[t] = 1;
               tap = dir ? tap + 1 : tap - 1;
            end
            e_upd[t] = 1;
            e_tap[t] = tap;
            rem--;
            endk = t + G;
            if (endk >= oor_rel) begin
               err = 1;
               break;
            end
            t = t + G + 1;
         end
         dk = endk + P + 1;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the cycle REQ_READY is back.
   task automatic run_req(input bit sel, input bit ld, input bit dir, input int cnt, input int oor_rel);
      int dk, cur;
      bit eerr;
      logic [22:0] obs, exp;
      build(sel, ld, dir, cnt, oor_rel, dk, eerr);
      chk("ready_before", {31'd0, REQ_READY}, 32'd1);
      REQ_VALID = 1; REQ_SEL = sel; REQ_LOAD = ld; REQ_DIR = dir; REQ_COUNT = 8'(cnt);
      RX_OOR = 0; TX_OOR = 0;
      cur = sel ? m_tx : m_rx;
      for (int k = 1; k <= dk + 1; k++) begin
         @(negedge FAB_CLK);
         if (e_upd[k]) cur = e_tap[k];
         obs = {REQ_READY, PAUSE, DL_MOVE, DL_LOAD, DONE, DL_SEL, DL_DIR, RX_TAP, TX_TAP};
         exp = {k > dk, k < dk, e_move[k], e_load[k], k == dk, sel, dir,
                8'(sel ? m_rx : cur), 8'(sel ? cur : m_tx)};
         chk($sformatf("cyc%0d rdy/pause/mv/ld/done/sel/dir/rx/tx", k), {9'd0, obs}, {9'd0, exp});
         if (k == 1)  chk("err_cleared", {31'd0, ERR}, 32'd0);
         if (k >= dk) chk($sformatf("err_cyc%0d", k), {31'd0, ERR}, {31'd0, eerr});
         if (k <= dk) begin
            REQ_VALID = 1'($urandom); REQ_SEL = 1'($urandom); REQ_LOAD = 1'($urandom);
            REQ_DIR = 1'($urandom); REQ_COUNT = 8'($urandom);
            if (sel) begin TX_OOR = (k >= oor_rel); RX_OOR = 1'($urandom); end
            else     begin RX_OOR = (k >= oor_rel); TX_OOR = 1'($urandom); end
         end else begin
            REQ_VALID = 0; RX_OOR = 0; TX_OOR = 0;
         end
      end
      if (sel) m_tx = cur; else m_rx = cur;
   endtask

   task automatic reset_vals(input string tag);
      logic [22:0] obs;
      obs = {REQ_READY, PAUSE, DL_MOVE, DL_LOAD, DONE, DL_SEL, DL_DIR, RX_TAP, TX_TAP};
      chk(tag, {8'd0, obs, ERR}, {8'd0, 1'b1, 6'd0, 8'(TDEF), 8'(TDEF), 1'b0});
   endtask

   initial begin
      // Reset state, with junk on REQ_VALID that must be ignored.
      REQ_VALID = 1; REQ_COUNT = 8'd7;
      repeat (3) @(negedge FAB_CLK);
      reset_vals("reset_state");
      REQ_VALID = 0;
      RESET_N = 1;
      @(negedge FAB_CLK);
      reset_vals("after_release");

      run_req(0, 0, 1, 3, 9999);            // RX +3: pulses T+3/7/11, DONE T+17
      chk("rx_after_inc", {24'd0, RX_TAP}, 32'd4);
      run_req(1, 0, 1, 4, 9999);            // TX to tap 5
      run_req(1, 1, 0, 9, 9999);            // TX load, COUNT ignored
      chk("tx_after_load", {24'd0, TX_TAP}, 32'd1);
      run_req(0, 1, 1, 0, 9999);            // RX back to 1
      run_req(0, 0, 0, 3, 9999);            // RX -3 from 1: saturates at 0
      chk("rx_floor", {24'd0, RX_TAP}, 32'd0);
      run_req(1, 0, 1, 4, 5);               // TX +4 aborted by lane flag
      chk("tx_oor_abort", {24'd0, TX_TAP}, 32'd2);
      run_req(0, 0, 1, 0, 9999);            // zero move, clears ERR
      run_req(1, 0, 0, 0, 9999);            // back-to-back zero move
      run_req(0, 1, 0, 0, 9999);
      run_req(0, 0, 1, 255, 9999);          // RX 1 -> 255 then ceiling
      chk("rx_ceiling", {24'd0, RX_TAP}, 32'd255);

      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 2)) @(negedge FAB_CLK);
         run_req(1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), $urandom_range(0, 6),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 9999);
      end

      // Reset in the first GAP of an RX +3 request.
      REQ_VALID = 1; REQ_SEL = 0; REQ_LOAD = 0; REQ_DIR = 1; REQ_COUNT = 8'd3;
      @(negedge FAB_CLK);
      REQ_VALID = 0;
      repeat (4) @(negedge FAB_CLK);
      chk("pre_reset_pause", {31'd0, PAUSE}, 32'd1);
      #2 RESET_N = 0;
      #1 reset_vals("mid_gap_reset");
      @(negedge FAB_CLK);
      reset_vals("held_reset");
      RESET_N = 1;
      m_rx = TDEF; m_tx = TDEF;
      @(negedge FAB_CLK);
      run_req(0, 0, 1, 3, 9999);
      chk("rx_after_rerun", {24'd0, RX_TAP}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lpddr3_lane_dly_move_ctrl.md
# lpddr3_lane_dly_move_ctrl

Sequencer that sits directly upstream of each LPDDR3 lane controller and drives its delay-line control pins: DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE and HS_IO_CLK_PAUSE. It accepts tap-move or tap-load requests from the training engine over a valid/ready handshake and wraps every request in an HS_IO_CLK_PAUSE window. It keeps shadow tap counters for the RX DQS and TX DQS delay lines and flags range violations, whether predicted from the shadow counters or reported back by the lane.

## Interface
- TAP_MAX, 255: highest legal tap value (≤255).
- DEFAULT_TAP, 1: tap value after reset or a load; matches the lane's 8'b00000001 delay default.
- PAUSE_LEAD, 2: cycles of HS_IO_CLK_PAUSE before the first pulse (≥1).
- MOVE_GAP, 3: idle cycles after every pulse (≥1).
- PAUSE_TRAIL, 2: cycles of HS_IO_CLK_PAUSE after the last gap (≥1).

Ports (name, direction, width, meaning):
- FAB_CLK  in  1  sole clock, fabric domain.
- RESET_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE.
- REQ_SEL  in  1  0 = RX DQS line, 1 = TX DQS line.
- REQ_LOAD  in  1  1 = load the line to its default value; REQ_DIR and REQ_COUNT are ignored.
- REQ_DIR  in  1  1 = increment, 0 = decrement.
- REQ_COUNT  in  8  number of taps to move.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky range error; cleared on the next accepted request.
- RX_TAP, TX_TAP  out  8 each  shadow tap counters.
- DELAY_LINE_SEL, DELAY_LINE_DIRECTION  out  1 each  captured REQ_SEL and REQ_DIR.
- DELAY_LINE_LOAD, DELAY_LINE_MOVE  out  1 each  one-cycle pulses.
- HS_IO_CLK_PAUSE  out  1  pause window to the lane.
- RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE  in  1 each  lane status flags.

## Operation
- States: IDLE, PRE, PULSE, GAP, POST, FIN.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, the request is accepted: SEL, LOAD, DIR and COUNT are captured and ERR is cleared.
  - If LOAD=0 and COUNT=0, go to FIN; there is no pause and no pulse.
  - Otherwise go to PRE.
- PRE: HS_IO_CLK_PAUSE=1 for PAUSE_LEAD cycles, then go to PULSE.
- PULSE:
  - Load request: DELAY_LINE_LOAD=1 for one cycle, and the selected tap counter is set to DEFAULT_TAP.
  - Move request, when the selected tap is not TAP_MAX on an increment and not 0 on a decrement: DELAY_LINE_MOVE=1 for one cycle, the tap counter moves by ±1, and the remaining count is decremented.
  - Move request, when the tap is already at the limit: no pulse is issued. ERR=1, the remaining count is discarded, and the state goes straight to POST.
- GAP:
  - Lasts MOVE_GAP cycles.
  - On the last GAP cycle the selected lane OUT_OF_RANGE flag is sampled. If it is 1, ERR=1 and the state goes to POST, discarding the remaining count.
  - Otherwise, go to PULSE if the remaining count is greater than 0, else to POST.
- POST: HS_IO_CLK_PAUSE=1 for PAUSE_TRAIL cycles, then go to FIN.
- FIN: DONE=1 and HS_IO_CLK_PAUSE=0 for one cycle, then return to IDLE.
- HS_IO_CLK_PAUSE is high in every PRE, PULSE, GAP and POST cycle, with no gaps.
- DELAY_LINE_SEL and DELAY_LINE_DIRECTION are driven from the captured values. They hold from the cycle after accept until the next accept.
- The unselected tap counter never changes.
- A request with LOAD=1 and COUNT≠0 performs only the load.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE; REQ_READY=1 (REQ_VALID is ignored while RESET_N=0).
  - DONE, ERR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, DELAY_LINE_SEL and DELAY_LINE_DIRECTION are 0.
  - RX_TAP = TX_TAP = DEFAULT_TAP.
- Reset asserted mid-request: all outputs return to their reset values immediately. A pause or pulse in progress is cut, and no DONE is issued.
- Notation: accept cycle T, N moves, lead L, gap G, trail P.
  - Pause window: T+1 to T+L+N(G+1)+P.
  - Pulses at T+L+1+k(G+1), for k = 0 to N-1.
  - DONE at T+L+N(G+1)+P+1.
  - REQ_READY returns at T+L+N(G+1)+P+2.
- Load request: pulse at T+L+1, DONE at T+L+G+P+2.
- COUNT=0 with LOAD=0: DONE at T+1, REQ_READY returns at T+2.
- Tap counters update in the cycle where DELAY_LINE_MOVE or DELAY_LINE_LOAD is 1.
- Counter arithmetic is 8-bit unsigned, with saturation enforced by the pre-check; the counters never wrap.

## Test plan
- Reset, then RX request with DIR=1, COUNT=3 and default parameters:
  - Pause high T+1 to T+16.
  - MOVE pulses at T+3, T+7 and T+11, with SEL=0 and DIRECTION=1.
  - DONE at T+17; RX_TAP=4, TX_TAP=1.
- TX load after moving the TX line to tap 5:
  - LOAD pulse at T+3, DONE at T+9.
  - TX_TAP=1, and RX_TAP is unchanged.
- RX decrement of 3 starting from tap 1:
  - One MOVE pulse at T+3, taking RX_TAP to 0.
  - The second PULSE finds the tap at 0: no pulse, ERR=1.
  - The state goes to POST; DONE at T+10.
- TX increment of 4 with TX_DELAY_LINE_OUT_OF_RANGE forced to 1 before T+6:
  - One pulse, then abort with ERR=1 and TX_TAP=2.
  - The next accepted request clears ERR.
- COUNT=0 with LOAD=0:
  - DONE at T+1, no pause and no pulse.
  - Back-to-back REQ_VALID is accepted at T+2.
- Deassert RESET_N while the state is GAP:
  - HS_IO_CLK_PAUSE, MOVE and DONE drop to 0 immediately, and the taps return to 1.
  - The first request after release behaves exactly as in the first scenario.
